// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO writer/reader pair and sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic [CNT_WIDTH-1:0]  available;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  full, almost_full, available, overflow,
               rd_data, rd_valid, empty, almost_empty, count, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output full, almost_full, available, overflow,
               rd_data, rd_valid, empty, almost_empty, count, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO, any depth >= 2, registered-read or FWFT output,
// occupancy counts, almost flags, synchronous flush and overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 10,
    parameter int FWFT       = 0,
    parameter int AF_THR     = FIFO_DEPTH - 1,
    parameter int AE_THR     = 1
) (
    input logic              clk,
    input logic              arst,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  empty_w;
    logic                  full_w;
    logic                  rd_acc;
    logic                  wr_acc;

    // Index wraps at FIFO_DEPTH-1 rather than at a power of two; the MSB toggles on each lap.
    function automatic logic [ADDR_WIDTH:0] next_ptr(input logic [ADDR_WIDTH:0] ptr);
        if (ptr[ADDR_WIDTH-1:0] == LAST_IDX)
            next_ptr = {~ptr[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}};
        else
            next_ptr = ptr + (ADDR_WIDTH + 1)'(1);
    endfunction

    assign wr_idx  = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_idx  = rd_ptr[ADDR_WIDTH-1:0];
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_idx == rd_idx) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
    assign rd_acc = bus.rd_en & ~empty_w;
    assign wr_acc = bus.wr_en & (~full_w | rd_acc);

    always_comb begin
        cnt_next = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_next = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_next = cnt_q - CNT_WIDTH'(1);
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
            cnt_q       <= cnt_next;
            overflow_q  <= bus.wr_en & ~wr_acc;
            underflow_q <= bus.rd_en & empty_w;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush)
            mem[wr_idx] <= bus.wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = mem[rd_idx];
            assign bus.rd_valid = ~empty_w;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // The edge that captures the head also frees its slot, so a same-cycle write
            // into that slot cannot be observed here (read-before-write).
            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (bus.flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_idx];
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = cnt_q;
    assign bus.available    = DEPTH_C - cnt_q;
    assign bus.almost_full  = (int'(cnt_q) >= AF_THR);
    assign bus.almost_empty = (int'(cnt_q) <= AE_THR);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: registered-read FIFO, an FWFT FIFO and a FIFO with custom almost thresholds.
module tb_sync_fifo_param;
    logic clk;
    logic arst;
    int   checks;
    int   errors;

    sync_fifo_param_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) f0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) f1 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) f2 ();

    sync_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(10), .FWFT(0)) u_reg (
        .clk(clk), .arst(arst), .bus(f0.slave)
    );
    sync_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(10), .FWFT(1)) u_fwft (
        .clk(clk), .arst(arst), .bus(f1.slave)
    );
    sync_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(10), .FWFT(0), .AF_THR(8), .AE_THR(2)) u_thr (
        .clk(clk), .arst(arst), .bus(f2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #2 arst = 1'b0;
        tick();
        tick();
        checks++; if (f0.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", f0.count); end
        checks++; if (f0.available !== 4'd10) begin errors++; $display("FAIL reset_available: got %0d expected 10", f0.available); end
        checks++; if ({f0.empty, f0.almost_empty, f0.full, f0.almost_full} !== 4'b1100) begin
            errors++; $display("FAIL reset_flags: got %b expected 1100", {f0.empty, f0.almost_empty, f0.full, f0.almost_full}); end
        checks++; if ({f0.rd_valid, f0.overflow, f0.underflow} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {f0.rd_valid, f0.overflow, f0.underflow}); end
        checks++; if (f0.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", f0.rd_data); end
        checks++; if ({f1.rd_valid, f1.empty} !== 2'b01) begin errors++; $display("FAIL reset_fwft_flags: got %b expected 01", {f1.rd_valid, f1.empty}); end
        arst = 1'b1;
        tick();
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 10; i++) begin
            f0.wr_en = 1'b1; f0.wr_data = 8'(i);
            tick();
            if (i == 8) begin
                checks++; if (f0.almost_full !== 1'b0) begin errors++; $display("FAIL af_at_8: got %b expected 0", f0.almost_full); end
            end
            if (i == 9) begin
                checks++; if ({f0.almost_full, f0.full} !== 2'b10) begin errors++; $display("FAIL af_at_9: got %b expected 10", {f0.almost_full, f0.full}); end
            end
        end
        checks++; if ({f0.full, f0.almost_full, f0.empty} !== 3'b110) begin errors++; $display("FAIL full_flags: got %b expected 110", {f0.full, f0.almost_full, f0.empty}); end
        checks++; if (f0.available !== 4'd0) begin errors++; $display("FAIL full_available: got %0d expected 0", f0.available); end
        checks++; if (f0.overflow !== 1'b0) begin errors++; $display("FAIL no_overflow_yet: got %b expected 0", f0.overflow); end
        f0.wr_data = 8'h77;
        tick();
        checks++; if (f0.overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b expected 1", f0.overflow); end
        checks++; if (f0.count !== 4'd10) begin errors++; $display("FAIL overflow_count: got %0d expected 10", f0.count); end
        f0.wr_en = 1'b0;
        tick();
        checks++; if (f0.overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle: got %b expected 0", f0.overflow); end
    endtask

    task automatic test_drain_underflow();
        f0.rd_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if ({f0.rd_valid, f0.rd_data} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, f0.rd_valid, f0.rd_data, 8'(i)); end
        end
        f0.rd_en = 1'b0;
        tick();
        checks++; if ({f0.rd_valid, f0.empty, f0.underflow} !== 3'b010) begin
            errors++; $display("FAIL drained_state: got %b expected 010", {f0.rd_valid, f0.empty, f0.underflow}); end
        checks++; if (f0.rd_data !== 8'h0A) begin errors++; $display("FAIL rd_data_hold: got %h expected 0a", f0.rd_data); end
        f0.rd_en = 1'b1;
        tick();
        checks++; if ({f0.underflow, f0.rd_valid} !== 2'b10) begin errors++; $display("FAIL underflow_pulse: got %b expected 10", {f0.underflow, f0.rd_valid}); end
        f0.rd_en = 1'b0;
        tick();
        checks++; if (f0.underflow !== 1'b0) begin errors++; $display("FAIL underflow_one_cycle: got %b expected 0", f0.underflow); end
    endtask

    task automatic test_full_rd_wr();
        logic [7:0] exp_q [10];
        for (int i = 1; i <= 10; i++) begin
            f0.wr_en = 1'b1; f0.wr_data = 8'(i);
            tick();
        end
        f0.rd_en = 1'b1; f0.wr_data = 8'hFF;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if ({f0.rd_data, f0.count, f0.overflow} !== {8'(i), 4'd10, 1'b0}) begin
                errors++; $display("FAIL full_rw_%0d: got data=%h count=%0d ovf=%b expected data=%h count=10 ovf=0", i, f0.rd_data, f0.count, f0.overflow, 8'(i)); end
        end
        f0.wr_en = 1'b0;
        for (int i = 0; i < 10; i++) exp_q[i] = (i < 7) ? 8'(i + 4) : 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (f0.rd_data !== exp_q[i]) begin errors++; $display("FAIL full_rw_drain_%0d: got %h expected %h", i, f0.rd_data, exp_q[i]); end
        end
        f0.rd_en = 1'b0;
        tick();
        checks++; if (f0.empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b expected 1", f0.empty); end
    endtask

    task automatic test_empty_rd_wr();
        f0.rd_en = 1'b1; f0.wr_en = 1'b1; f0.wr_data = 8'h55;
        tick();
        checks++; if ({f0.underflow, f0.count, f0.rd_valid} !== {1'b1, 4'd1, 1'b0}) begin
            errors++; $display("FAIL empty_rw: got unf=%b count=%0d valid=%b expected 1 1 0", f0.underflow, f0.count, f0.rd_valid); end
        f0.wr_en = 1'b0;
        tick();
        checks++; if ({f0.rd_valid, f0.rd_data, f0.empty, f0.underflow} !== {1'b1, 8'h55, 1'b1, 1'b0}) begin
            errors++; $display("FAIL empty_rw_read: got valid=%b data=%h empty=%b unf=%b expected 1 55 1 0", f0.rd_valid, f0.rd_data, f0.empty, f0.underflow); end
        f0.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_fwft();
        f1.wr_en = 1'b1; f1.wr_data = 8'h33;
        checks++; if (f1.rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_not_yet: got %b expected 0", f1.rd_valid); end
        tick();
        checks++; if ({f1.rd_valid, f1.rd_data} !== {1'b1, 8'h33}) begin
            errors++; $display("FAIL fwft_head: got valid=%b data=%h expected 1 33", f1.rd_valid, f1.rd_data); end
        f1.wr_data = 8'h44;
        tick();
        f1.wr_en = 1'b0; f1.rd_en = 1'b1;
        tick();
        checks++; if ({f1.rd_valid, f1.rd_data, f1.count} !== {1'b1, 8'h44, 4'd1}) begin
            errors++; $display("FAIL fwft_pop1: got valid=%b data=%h count=%0d expected 1 44 1", f1.rd_valid, f1.rd_data, f1.count); end
        tick();
        checks++; if ({f1.rd_valid, f1.empty} !== 2'b01) begin errors++; $display("FAIL fwft_pop2: got %b expected 01", {f1.rd_valid, f1.empty}); end
        f1.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_thresholds_flush();
        f2.wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            f2.wr_data = 8'(8'hA0 + i);
            tick();
            if (i == 2) begin
                checks++; if (f2.almost_empty !== 1'b1) begin errors++; $display("FAIL ae_at_2: got %b expected 1", f2.almost_empty); end
            end
            if (i == 3) begin
                checks++; if (f2.almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at_3: got %b expected 0", f2.almost_empty); end
            end
            if (i == 7) begin
                checks++; if (f2.almost_full !== 1'b0) begin errors++; $display("FAIL af_thr_at_7: got %b expected 0", f2.almost_full); end
            end
        end
        checks++; if ({f2.almost_full, f2.full} !== 2'b10) begin errors++; $display("FAIL af_thr_at_8: got %b expected 10", {f2.almost_full, f2.full}); end
        f2.wr_en = 1'b0; f2.rd_en = 1'b1;
        tick(); tick(); tick();
        f2.rd_en = 1'b0;
        checks++; if (f2.count !== 4'd5) begin errors++; $display("FAIL pre_flush_count: got %0d expected 5", f2.count); end
        f2.flush = 1'b1; f2.wr_en = 1'b1; f2.rd_en = 1'b1; f2.wr_data = 8'hEE;
        tick();
        f2.flush = 1'b0; f2.wr_en = 1'b0; f2.rd_en = 1'b0;
        checks++; if ({f2.count, f2.empty, f2.almost_empty, f2.almost_full} !== {4'd0, 3'b110}) begin
            errors++; $display("FAIL flush_state: got count=%0d flags=%b expected 0 110", f2.count, {f2.empty, f2.almost_empty, f2.almost_full}); end
        checks++; if ({f2.rd_valid, f2.overflow, f2.underflow, f2.rd_data} !== {3'b000, 8'hA3}) begin
            errors++; $display("FAIL flush_outputs: got pulses=%b data=%h expected 000 a3", {f2.rd_valid, f2.overflow, f2.underflow}, f2.rd_data); end
        checks++; if (f2.available !== 4'd10) begin errors++; $display("FAIL flush_available: got %0d expected 10", f2.available); end
    endtask

    task automatic test_async_reset_mid();
        f0.wr_en = 1'b1; f0.wr_data = 8'h12;
        tick(); tick();
        f0.wr_en = 1'b0; f0.rd_en = 1'b1;
        tick();
        f0.rd_en = 1'b0;
        checks++; if ({f0.count, f0.rd_data} !== {4'd1, 8'h12}) begin
            errors++; $display("FAIL pre_reset: got count=%0d data=%h expected 1 12", f0.count, f0.rd_data); end
        #1 arst = 1'b0;
        #1;
        checks++; if ({f0.count, f0.empty, f0.rd_data, f0.rd_valid} !== {4'd0, 1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL async_reset: got count=%0d empty=%b data=%h valid=%b expected 0 1 00 0", f0.count, f0.empty, f0.rd_data, f0.rd_valid); end
        arst = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        f0.flush = 1'b0; f0.wr_en = 1'b0; f0.wr_data = '0; f0.rd_en = 1'b0;
        f1.flush = 1'b0; f1.wr_en = 1'b0; f1.wr_data = '0; f1.rd_en = 1'b0;
        f2.flush = 1'b0; f2.wr_en = 1'b0; f2.wr_data = '0; f2.rd_en = 1'b0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rd_wr();
        test_empty_rd_wr();
        test_fwft();
        test_thresholds_flush();
        test_async_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
